// File: rtl/maxi_initiator.sv
// maxi_initiator: AXI3-style single-outstanding bus initiator.
//
// Accepts one read or write command at a time on the req channel, issues the
// address phase on AR or AW, moves the data beats between the user ports
// (wdata/rdata) and the W/R channels, collects the B response for writes, and
// reports completion with a one-cycle done pulse carrying an error code.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_*                         command in: write, addr, id, len (beats-1); req_rdy only in IDLE
//   wdata_*                       user write beats in; wdata_rdy = WDATA && w_rdy
//   rdata_*                       user read beats out (pass-through of R)
//   done_*                        completion pulse: write, id, err
//                                 err[0] resp!=0, [1] id mismatch, [2] last mismatch, [3] timeout
//   ar_*, aw_*, w_*               address/write-data channels driven to the responder
//   r_*, b_*                      read-data/write-response channels from the responder
module maxi_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 12,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // command
  input  logic              req_ena,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_rdy,
  // user write beats
  input  logic              wdata_ena,
  input  logic [DATA_W-1:0] wdata_data,
  output logic              wdata_rdy,
  // user read beats
  output logic              rdata_ena,
  output logic [DATA_W-1:0] rdata_data,
  output logic              rdata_last,
  input  logic              rdata_rdy,
  // completion
  output logic              done_ena,
  output logic              done_write,
  output logic [ID_W-1:0]   done_id,
  output logic [3:0]        done_err,
  // read address channel
  output logic              ar_ena,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [ID_W-1:0]   ar_id,
  output logic [LEN_W-1:0]  ar_len,
  input  logic              ar_rdy,
  // write address channel
  output logic              aw_ena,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [ID_W-1:0]   aw_id,
  output logic [LEN_W-1:0]  aw_len,
  input  logic              aw_rdy,
  // write data channel
  output logic              w_ena,
  output logic [DATA_W-1:0] w_data,
  output logic [ID_W-1:0]   w_id,
  output logic              w_last,
  input  logic              w_rdy,
  // read data channel
  input  logic              r_ena,
  input  logic [DATA_W-1:0] r_data,
  input  logic [ID_W-1:0]   r_id,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  output logic              r_rdy,
  // write response channel
  input  logic              b_ena,
  input  logic [ID_W-1:0]   b_id,
  input  logic [1:0]        b_resp,
  output logic              b_rdy
);

  // Idle-cycle counter is wide enough to hold TIMEOUT; one extra bit for the increment.
  localparam int unsigned TO_W = $clog2(TIMEOUT + 2);
  localparam int unsigned TC_W = TO_W + 1;

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE
  } state_t;

  state_t            state;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic [3:0]        err;

  logic              r_xfer;
  logic              b_xfer;
  logic              last_beat;
  logic              hs;
  logic              waiting;
  logic              tmo;
  logic [TC_W-1:0]   tcnt_inc;

  // Channel handshakes: every ENA is qualified by the matching RDY.
  assign req_rdy    = (state == IDLE);
  assign ar_ena     = (state == RADDR) && ar_rdy;
  assign aw_ena     = (state == WADDR) && aw_rdy;
  assign wdata_rdy  = (state == WDATA) && w_rdy;
  assign w_ena      = wdata_ena && wdata_rdy;
  assign r_rdy      = (state == RDATA) && rdata_rdy;
  assign b_rdy      = (state == WRESP);

  assign ar_addr    = addr_q;
  assign ar_id      = id_q;
  assign ar_len     = len_q;
  assign aw_addr    = addr_q;
  assign aw_id      = id_q;
  assign aw_len     = len_q;
  assign w_data     = wdata_data;
  assign w_id       = id_q;
  assign w_last     = last_beat;

  assign rdata_ena  = r_ena;
  assign rdata_data = r_data;
  assign rdata_last = r_last;

  assign done_ena   = (state == DONE);
  assign done_write = wr_q;
  assign done_id    = id_q;
  assign done_err   = err;

  assign r_xfer     = r_ena && r_rdy;
  assign b_xfer     = b_ena && b_rdy;
  assign last_beat  = (cnt == len_q);
  assign hs         = ar_ena || aw_ena || w_ena || r_xfer || b_xfer;

  // Abort when this idle cycle would bring the count up to TIMEOUT.
  assign waiting    = (state != IDLE) && (state != DONE);
  assign tcnt_inc   = TC_W'(tcnt) + TC_W'(1);
  assign tmo        = (TIMEOUT != 0) && waiting && !hs && (tcnt_inc == TC_W'(TIMEOUT));

  // Transaction FSM with command latch, beat counter, idle counter and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      addr_q <= '0;
      id_q   <= '0;
      len_q  <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      err    <= '0;
    end else begin
      if (!waiting || hs || tmo) tcnt <= '0;
      else                       tcnt <= tcnt_inc[TO_W-1:0];

      if (tmo) begin
        err[3] <= 1'b1;
        state  <= DONE;
      end else begin
        case (state)
          IDLE: begin
            if (req_ena) begin
              wr_q   <= req_write;
              addr_q <= req_addr;
              id_q   <= req_id;
              len_q  <= req_len;
              err    <= '0;
              state  <= req_write ? WADDR : RADDR;
            end
          end
          RADDR: begin
            if (ar_ena) begin
              cnt   <= '0;
              state <= RDATA;
            end
          end
          RDATA: begin
            if (r_xfer) begin
              err <= err | {1'b0, (r_last != last_beat), (r_id != id_q), (r_resp != 2'b00)};
              // The beat count alone ends the burst; r_last only feeds the error code.
              if (last_beat) state <= DONE;
              else           cnt   <= cnt + LEN_W'(1);
            end
          end
          WADDR: begin
            if (aw_ena) begin
              cnt   <= '0;
              state <= WDATA;
            end
          end
          WDATA: begin
            if (w_ena) begin
              if (last_beat) state <= WRESP;
              else           cnt   <= cnt + LEN_W'(1);
            end
          end
          WRESP: begin
            if (b_xfer) begin
              err   <= err | {2'b00, (b_id != id_q), (b_resp != 2'b00)};
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maxi_initiator.sv
// tb_maxi_initiator: plays user and responder around maxi_initiator, with a
// transaction-level expectation of beat counts, payloads and the error code.
module tb_maxi_initiator;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 12;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req_ena, req_write, req_rdy;
  logic [ADDR_W-1:0] req_addr;
  logic [ID_W-1:0]   req_id;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_ena, wdata_rdy;
  logic [DATA_W-1:0] wdata_data;
  logic              rdata_ena, rdata_last, rdata_rdy;
  logic [DATA_W-1:0] rdata_data;
  logic              done_ena, done_write;
  logic [ID_W-1:0]   done_id;
  logic [3:0]        done_err;
  logic              ar_ena, ar_rdy, aw_ena, aw_rdy;
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic [ID_W-1:0]   ar_id, aw_id;
  logic [LEN_W-1:0]  ar_len, aw_len;
  logic              w_ena, w_last, w_rdy;
  logic [DATA_W-1:0] w_data;
  logic [ID_W-1:0]   w_id;
  logic              r_ena, r_last, r_rdy;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_resp;
  logic              b_ena, b_rdy;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;

  int checks = 0;
  int errors = 0;

  maxi_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_ena(req_ena), .req_write(req_write), .req_addr(req_addr), .req_id(req_id),
    .req_len(req_len), .req_rdy(req_rdy),
    .wdata_ena(wdata_ena), .wdata_data(wdata_data), .wdata_rdy(wdata_rdy),
    .rdata_ena(rdata_ena), .rdata_data(rdata_data), .rdata_last(rdata_last), .rdata_rdy(rdata_rdy),
    .done_ena(done_ena), .done_write(done_write), .done_id(done_id), .done_err(done_err),
    .ar_ena(ar_ena), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_rdy(ar_rdy),
    .aw_ena(aw_ena), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_rdy(aw_rdy),
    .w_ena(w_ena), .w_data(w_data), .w_id(w_id), .w_last(w_last), .w_rdy(w_rdy),
    .r_ena(r_ena), .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last), .r_rdy(r_rdy),
    .b_ena(b_ena), .b_id(b_id), .b_resp(b_resp), .b_rdy(b_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit coin(input bit busy);
    return !busy || ($urandom_range(3) != 0);
  endfunction

  // One complete command. Masks pick which read beats carry a bad id, a
  // non-OKAY resp or a flipped last flag; no_r keeps the responder silent.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                         input logic [LEN_W-1:0] len, input logic [15:0] id_mask,
                         input logic [15:0] resp_mask, input logic [15:0] last_mask,
                         input logic [1:0] bresp, input bit bid_bad, input int addr_stall,
                         input bit no_r, input bit busy);
    int nb, cyc, addr_cyc, done_cyc, beats_in, beats_out, rcount;
    bit addr_done, b_done, got_done;
    logic [15:0] bm;
    logic [3:0] exp_err;
    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] rq[$];
    nb = int'(len) + 1;
    bm = (nb == 16) ? 16'hFFFF : 16'((32'd1 << nb) - 1);
    if (wr) exp_err = {2'b00, bid_bad, bresp != 2'b00};
    else    exp_err = {no_r, |(last_mask & bm), |(id_mask & bm), |(resp_mask & bm)};
    cyc = 0; addr_cyc = -1; done_cyc = -1; beats_in = 0; beats_out = 0; rcount = 0;
    addr_done = 0; b_done = 0; got_done = 0;

    @(negedge clk);
    #1 chk("req_rdy_idle", req_rdy, 1);
    req_ena = 1; req_write = wr; req_addr = addr; req_id = id; req_len = len;
    @(negedge clk);
    req_ena = 0;
    while (!got_done && cyc < 200) begin
      ar_rdy = (cyc >= addr_stall) && coin(busy);
      aw_rdy = (cyc >= addr_stall) && coin(busy);
      w_rdy = coin(busy);
      rdata_rdy = coin(busy);
      r_ena = 0; wdata_ena = 0; b_ena = 0;
      #1;
      if (cyc == 0) chk("req_rdy_busy", req_rdy, 0);
      if (!wr && !no_r && beats_out < nb && r_rdy && coin(busy)) begin
        r_ena = 1;
        r_data = $urandom;
        r_id = id_mask[beats_out] ? id + ID_W'(1) : id;
        r_resp = resp_mask[beats_out] ? 2'($urandom_range(3, 1)) : 2'b00;
        r_last = (beats_out == nb - 1) ^ last_mask[beats_out];
        rq.push_back(r_data);
        beats_out++;
      end
      if (wr && beats_in < nb && wdata_rdy && coin(busy)) begin
        wdata_ena = 1;
        wdata_data = $urandom;
        wq.push_back(wdata_data);
      end
      if (wr && beats_in == nb && !b_done && b_rdy && coin(busy)) begin
        b_ena = 1;
        b_id = bid_bad ? ~id : id;
        b_resp = bresp;
      end
      #1;
      if (cyc < addr_stall) chk("addr_stall", {ar_ena, aw_ena}, 0);
      if (ar_ena) begin
        chk("ar_once", addr_done, 0);
        chk("ar_fields", {wr, ar_rdy, ar_addr, ar_id, ar_len}, {1'b0, 1'b1, addr, id, len});
        addr_done = 1; addr_cyc = cyc;
      end
      if (aw_ena) begin
        chk("aw_once", addr_done, 0);
        chk("aw_fields", {wr, aw_rdy, aw_addr, aw_id, aw_len}, {1'b1, 1'b1, addr, id, len});
        addr_done = 1; addr_cyc = cyc;
      end
      if (w_ena) begin
        chk("w_beat", {w_rdy, w_last, w_id, w_data},
            {1'b1, beats_in == nb - 1, id, wq[beats_in]});
        beats_in++;
      end
      if (rdata_ena) begin
        chk("rdata_beat", rdata_data, rq.pop_front());
        rcount++;
      end
      if (b_ena) b_done = 1;
      if (done_ena) begin
        got_done = 1; done_cyc = cyc;
        chk("done_fields", {done_write, done_id, done_err}, {wr, id, exp_err});
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", got_done, 1);
    if (wr) chk("w_beats", beats_in, nb);
    else    chk("r_beats", rcount, no_r ? 0 : nb);
    // With the responder silent, DONE follows the AR edge by TIMEOUT idle cycles plus one.
    if (no_r) chk("timeout_latency", done_cyc - addr_cyc, TIMEOUT + 1);
    if (addr_stall > 0 && !busy) chk("addr_after_stall", addr_cyc, addr_stall);
    rdata_rdy = 1;
    #1 chk("after_done", {done_ena, req_rdy, r_rdy, b_rdy}, 4'b0100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req_ena = 0; req_write = 0; req_addr = '0; req_id = '0; req_len = '0;
    wdata_ena = 0; wdata_data = '0; rdata_rdy = 0;
    ar_rdy = 0; aw_rdy = 0; w_rdy = 0;
    r_ena = 0; r_data = '0; r_id = '0; r_resp = '0; r_last = 0;
    b_ena = 0; b_id = '0; b_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    ar_rdy = 1; aw_rdy = 1; w_rdy = 1; rdata_rdy = 1; wdata_ena = 1;
    #1;
    chk("reset_state", {req_rdy, done_ena, ar_ena, aw_ena, w_ena, wdata_rdy, r_rdy, b_rdy},
        8'b1000_0000);
    chk("reset_err", done_err, 4'h0);
    wdata_ena = 0;

    // Clean read, len 3.
    run_txn(0, 32'h1000, 12'd5, 4'd3, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0);
    // Single-beat write to 0x40.
    run_txn(1, 32'h40, 12'd7, 4'd0, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0);
    // Read len 1: early last on beat 0, id 6 on every beat.
    run_txn(0, 32'h2000, 12'd5, 4'd1, 16'hFFFF, 16'h0, 16'h0001, 2'b00, 0, 0, 0, 0);
    // Write with SLVERR response and AW held off for 5 cycles.
    run_txn(1, 32'h3000, 12'd3, 4'd2, 16'h0, 16'h0, 16'h0, 2'b10, 0, 5, 0, 0);
    // Silent responder: timeout abort.
    run_txn(0, 32'h4000, 12'd9, 4'd2, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 1, 0);
    // Maximum length bursts.
    run_txn(0, 32'h5000, 12'hABC, 4'd15, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 0, 1);
    run_txn(1, 32'h6000, 12'h123, 4'd15, 16'h0, 16'h0, 16'h0, 2'b00, 1, 0, 0, 1);

    // Random traffic with random stalls and occasional error injection.
    for (int t = 0; t < 30; t++) begin
      logic [15:0] im, rm, lm;
      im = ($urandom_range(3) == 0) ? 16'(1 << $urandom_range(15)) : 16'h0;
      rm = ($urandom_range(3) == 0) ? 16'($urandom) : 16'h0;
      lm = ($urandom_range(3) == 0) ? 16'(1 << $urandom_range(15)) : 16'h0;
      run_txn(1'($urandom_range(1)), $urandom, 12'($urandom), 4'($urandom_range(15)),
              im, rm, lm, ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
              1'($urandom_range(3) == 0), 0, 0, 1);
    end

    // Reset in the middle of a 4-beat write after one beat.
    @(negedge clk);
    req_ena = 1; req_write = 1; req_addr = 32'h7000; req_id = 12'd11; req_len = 4'd3;
    aw_rdy = 1; w_rdy = 1;
    @(negedge clk);
    req_ena = 0;
    #1 chk("rst_aw", aw_ena, 1);
    @(negedge clk);
    wdata_data = 32'hCAFE0001; wdata_ena = 1;
    #1 chk("rst_first_beat", w_ena, 1);
    @(negedge clk);
    wdata_ena = 0; rst = 1;
    @(negedge clk);
    rst = 0; wdata_ena = 1;
    #1 chk("rst_recover", {req_rdy, w_ena, wdata_rdy, done_ena, b_rdy}, 5'b10000);
    wdata_ena = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("rst_no_done", {done_ena, req_rdy}, 2'b01);
    end

    // Normal service after the mid-transaction reset.
    run_txn(0, 32'h8000, 12'd1, 4'd2, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
